// File: rtl/piso_chain_pkg.sv
// Shared types and helpers for the piso_chain parallel-in/serial-out shifter.
package piso_chain_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Slice counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return (depth > 1) ? int'($clog2(depth)) : 1;
  endfunction

endpackage

// File: rtl/piso_stage.sv
// One WIDTH-bit slice register of the shift chain: load has priority over shift.
module piso_stage #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic [WIDTH-1:0] shift_data_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (load_i) begin
      data_d = load_data_i;
    end else if (shift_i) begin
      data_d = shift_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/piso_chain.sv
// Parallel-in/serial-out chain: one WIDTH*DEPTH word in, DEPTH slices out, MSB slice first.
// Define PISO_CHAIN_PARITY_EN to add the registered out_parity output.
module piso_chain
  import piso_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*DEPTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last
`ifdef PISO_CHAIN_PARITY_EN
  ,
  output logic                   out_parity
`endif
);

  localparam int unsigned CNT_W  = cnt_width(DEPTH);
  localparam int unsigned WORD_W = WIDTH * DEPTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] stage_flat;
  logic             load;
  logic             shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and slice counter; a load on the last slice wins over going idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SHIFT;
      cnt_d   = CNT_W'(DEPTH - 1);
    end else if (shift) begin
      if (cnt_q == '0) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Handshake outputs; in_ready sees out_ready only on the last slice.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
      end
      SHIFT: begin
        out_valid = 1'b1;
        out_last  = (cnt_q == '0);
        in_ready  = !rst && (cnt_q == '0) && out_ready;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign load  = in_valid && in_ready;
  assign shift = out_valid && out_ready;

  // Each stage takes its lower neighbour on shift; stage 0 fills with zero.
  piso_stage #(
    .WIDTH(WIDTH)
  ) u_stage [DEPTH-1:0] (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .shift_i     (shift),
    .load_data_i (in_data),
    .shift_data_i({stage_flat[WORD_W-WIDTH-1:0], {WIDTH{1'b0}}}),
    .data_o      (stage_flat)
  );

  assign out_data = stage_flat[WORD_W-1 -: WIDTH];

`ifdef PISO_CHAIN_PARITY_EN
  logic parity_q;
  logic parity_d;

  // Parity tracks whatever slice becomes the top register next.
  always_comb begin
    parity_d = parity_q;
    if (load) begin
      parity_d = ^in_data[WORD_W-1 -: WIDTH];
    end else if (shift) begin
      parity_d = ^stage_flat[WORD_W-WIDTH-1 -: WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

endmodule
